// File: rtl/regset_write_arbiter.sv
// regset_write_arbiter
//
// This module owns the single write port of the register set. It shares that
// port between two writeback requesters:
//   A = ALU/execute
//   B = load/memory
// When the optional clear feature is built in, it first writes zero through
// the same port to every register except x0. It also keeps a saturating count
// of contention cycles for performance debugging.
//
// Build option:
//   REGSET_CLEAR_EN  defined   -> CLEAR state present; x1..x(N-1) are zeroed
//                                 after every reset before RUN is entered.
//                    undefined -> no CLEAR state; the FSM is in RUN from
//                                 reset and clear_done is tied high.
//   REGISTER_COUNT   default number of architectural registers (32).
//
// Ports:
//   clk            clock, all state updates on posedge
//   res            asynchronous active-high reset
//   a_valid/a_ready/a_reg/a_data   requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data   requester B handshake and payload
//   write          write data to regset
//   write_reg      destination register to regset
//   write_enable   write strobe to regset
//   clear_done     register set is usable
//   conflict_count RUN cycles with both requesters valid (saturating)

`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

module regset_write_arbiter #(
  parameter int RegisterCount = `REGISTER_COUNT,
  parameter int StatWidth     = 16,
  parameter int WordWidth     = 32,
  localparam int RegWidth     = (RegisterCount > 1) ? $clog2(RegisterCount) : 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [RegWidth-1:0]  a_reg,
  input  logic [WordWidth-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RegWidth-1:0]  b_reg,
  input  logic [WordWidth-1:0] b_data,
  output logic [WordWidth-1:0] write,
  output logic [RegWidth-1:0]  write_reg,
  output logic                 write_enable,
  output logic                 clear_done,
  output logic [StatWidth-1:0] conflict_count
);

  logic                 in_run;
  logic                 arb_en;
  logic                 grant_a;
  logic                 grant_b;
  // 1 = B was granted last, so A wins the next tie.
  logic                 last_grant_b_reg;
  logic [StatWidth-1:0] conflict_count_reg;

`ifdef REGSET_CLEAR_EN
  localparam logic [RegWidth-1:0] LastReg = RegWidth'(RegisterCount - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t              state_reg;
  logic [RegWidth-1:0] clr_idx_reg;

  assign in_run     = (state_reg == ST_RUN);
  assign clear_done = in_run;
`else
  assign in_run     = 1'b1;
  assign clear_done = 1'b1;
`endif

  // Readies must drop as soon as reset is asserted, even without a CLEAR
  // state to fall back to, so the reset input gates the arbiter directly.
  assign arb_en  = in_run && !res;

  // Round-robin: on a tie, grant whichever side did not win last time.
  assign grant_a = arb_en && a_valid && (!b_valid ||  last_grant_b_reg);
  assign grant_b = arb_en && b_valid && (!a_valid || !last_grant_b_reg);

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign conflict_count = conflict_count_reg;

  // Write port mux. The port is idle (all zero) when nothing transfers.
  // A transfer to x0 is accepted but never strobes the register set.
  always_comb begin
    write        = '0;
    write_reg    = '0;
    write_enable = 1'b0;
`ifdef REGSET_CLEAR_EN
    if (state_reg == ST_CLEAR) begin
      write_reg    = clr_idx_reg;
      write_enable = 1'b1;
    end else
`endif
    if (grant_a) begin
      write        = a_data;
      write_reg    = a_reg;
      write_enable = (a_reg != '0);
    end else if (grant_b) begin
      write        = b_data;
      write_reg    = b_reg;
      write_enable = (b_reg != '0);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      last_grant_b_reg   <= 1'b1;
      conflict_count_reg <= '0;
`ifdef REGSET_CLEAR_EN
      state_reg          <= ST_CLEAR;
      clr_idx_reg        <= RegWidth'(1);
`endif
    end else begin
`ifdef REGSET_CLEAR_EN
      case (state_reg)
        ST_CLEAR: begin
          // Stop on the last index instead of incrementing past it, so a
          // power-of-two register count never wraps before the compare.
          if (clr_idx_reg == LastReg) begin
            state_reg <= ST_RUN;
          end else begin
            clr_idx_reg <= clr_idx_reg + RegWidth'(1);
          end
        end
        default: ;
      endcase
`endif
      if (grant_a) begin
        last_grant_b_reg <= 1'b0;
      end else if (grant_b) begin
        last_grant_b_reg <= 1'b1;
      end

      if (in_run && a_valid && b_valid && !(&conflict_count_reg)) begin
        conflict_count_reg <= conflict_count_reg + StatWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_regset_write_arbiter.sv
module tb_regset_write_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, write_enable, clear_done;
  logic [31:0] write;
  logic [4:0]  write_reg;
  logic [15:0] conflict_count;

  logic        s_a_ready, s_b_ready, s_write_enable, s_clear_done;
  logic [31:0] s_write;
  logic [4:0]  s_write_reg;
  logic [3:0]  s_conflict_count;

  int n_vec = 0;
  int n_err = 0;

`ifdef REGSET_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  always #5 clk = ~clk;

  regset_write_arbiter #(.RegisterCount(32), .StatWidth(16)) dut (
    .clk(clk), .res(res),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .write(write), .write_reg(write_reg), .write_enable(write_enable),
    .clear_done(clear_done), .conflict_count(conflict_count)
  );

  regset_write_arbiter #(.RegisterCount(32), .StatWidth(4)) dut4 (
    .clk(clk), .res(res),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_reg(b_reg), .b_data(b_data),
    .write(s_write), .write_reg(s_write_reg), .write_enable(s_write_enable),
    .clear_done(s_clear_done), .conflict_count(s_conflict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  // Called at the negedge where reset was released. Leaves RUN reached with
  // both requesters idle.
  task automatic clear_seq();
    if (ClearEn) begin
      drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd8, 32'h22);
      for (int i = 1; i < 32; i++) begin
        #1;
        chk("clr_we",      32'(write_enable),   32'd1);
        chk("clr_reg",     32'(write_reg),      32'(i));
        chk("clr_data",    write,               32'd0);
        chk("clr_rdy",     32'({a_ready, b_ready}), 32'd0);
        chk("clr_done",    32'(clear_done),     32'd0);
        @(negedge clk);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("clr_no_conflict", 32'(conflict_count), 32'd0);
    end else begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #1;
    end
    chk("clear_done_run", 32'(clear_done), 32'd1);
  endtask

  initial begin
    res = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset state, with a request pending that must not be accepted.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    #1;
    chk("rst_a_ready",  32'(a_ready),        32'd0);
    chk("rst_we",       32'(write_enable),   32'(ClearEn));
    chk("rst_reg",      32'(write_reg),      ClearEn ? 32'd1 : 32'd0);
    chk("rst_done",     32'(clear_done),     ClearEn ? 32'd0 : 32'd1);
    chk("rst_conflict", 32'(conflict_count), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    @(negedge clk);
    res = 1'b0;
    clear_seq();

    // Tie for four cycles: A wins the first tie, then strict alternation.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 32'hA0 + 32'(k), 1'b1, 5'd4, 32'hB0 + 32'(k));
      #1;
      chk("tie_a_ready", 32'(a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_b_ready", 32'(b_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("tie_reg",     32'(write_reg), (k % 2 == 0) ? 32'd3 : 32'd4);
      chk("tie_data",    write, (k % 2 == 0) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k));
      chk("tie_we",      32'(write_enable), 32'd1);
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("conflict_4",   32'(conflict_count),   32'd4);
    chk("conflict4_4",  32'(s_conflict_count), 32'd4);
    chk("idle_we",      32'(write_enable),     32'd0);
    chk("idle_reg",     32'(write_reg),        32'd0);
    chk("idle_data",    write,                 32'd0);
    chk("idle_rdy",     32'({a_ready, b_ready}), 32'd0);

    // A alone, zero-latency to the write port.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    chk("a_only_ready", 32'(a_ready),      32'd1);
    chk("a_only_b",     32'(b_ready),      32'd0);
    chk("a_only_we",    32'(write_enable), 32'd1);
    chk("a_only_reg",   32'(write_reg),    32'd5);
    chk("a_only_data",  write,             32'hDEADBEEF);

    // B alone to x0: accepted, never strobed.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'd7);
    #1;
    chk("x0_b_ready", 32'(b_ready),      32'd1);
    chk("x0_a_ready", 32'(a_ready),      32'd0);
    chk("x0_we",      32'(write_enable), 32'd0);
    chk("x0_data",    write,             32'd7);

    // Twenty tie cycles; B won last (x0 transfer), so A starts.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd10, 32'h1000 + 32'(k), 1'b1, 5'd11, 32'h2000 + 32'(k));
      #1;
      chk("sat_a_ready", 32'(a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("conflict_24",  32'(conflict_count),   32'd24);
    chk("conflict4_sat", 32'(s_conflict_count), 32'd15);

    // Reset in RUN: ready drops immediately, counters clear.
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    #1;
    chk("pre_rst_ready", 32'(a_ready), 32'd1);
    res = 1'b1;
    #1;
    chk("async_rst_ready",  32'(a_ready),          32'd0);
    chk("async_rst_cnt",    32'(conflict_count),   32'd0);
    chk("async_rst_cnt4",   32'(s_conflict_count), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    res = 1'b0;
    clear_seq();

    // Round-robin pointer was reset: A wins the first tie again, then B.
    @(negedge clk);
    drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    #1;
    chk("rr_rst_a", 32'(a_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("rr_next_b", 32'(b_ready), 32'd1);
    chk("rr_next_reg", 32'(write_reg), 32'd13);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset in the middle of CLEAR restarts the sequence from x1.
    if (ClearEn) begin
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      for (int i = 1; i < 10; i++) begin
        #1;
        chk("mid_clr_reg", 32'(write_reg), 32'(i));
        @(negedge clk);
      end
      #1;
      chk("mid_clr_reg10", 32'(write_reg), 32'd10);
      res = 1'b1;
      #1;
      chk("mid_clr_async_reg", 32'(write_reg),    32'd1);
      chk("mid_clr_async_we",  32'(write_enable), 32'd1);
      chk("mid_clr_done",      32'(clear_done),   32'd0);
      @(negedge clk);
      res = 1'b0;
      clear_seq();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
